// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared opcodes, FSM states and flag positions for alu_seq_core
package alu_seq_pkg;

   localparam logic [3:0] OP_ADD   = 4'h0;
   localparam logic [3:0] OP_ADDC  = 4'h1;
   localparam logic [3:0] OP_SUB   = 4'h2;
   localparam logic [3:0] OP_SUBB  = 4'h3;
   localparam logic [3:0] OP_RSUB  = 4'h4;
   localparam logic [3:0] OP_OR    = 4'h5;
   localparam logic [3:0] OP_XOR   = 4'h6;
   localparam logic [3:0] OP_AND   = 4'h7;
   localparam logic [3:0] OP_PASSA = 4'h8;
   localparam logic [3:0] OP_ADDK  = 4'h9;
   localparam logic [3:0] OP_PASSB = 4'hA;
   localparam logic [3:0] OP_SHL   = 4'hB;
   localparam logic [3:0] OP_SHR   = 4'hC;
   localparam logic [3:0] OP_SHRA  = 4'hD;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   localparam int FLAG_V = 0;
   localparam int FLAG_C = 1;
   localparam int FLAG_N = 2;
   localparam int FLAG_Z = 3;

endpackage

// File: rtl/alu_shift_unit.sv
// rtl/alu_shift_unit.sv - iterative 1-bit/cycle shifter; only built when ALU_SHIFT_EN is defined
`ifdef ALU_SHIFT_EN
module alu_shift_unit
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 32,
   localparam int SHW = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             step,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] data,
   input  logic [SHW-1:0]   shamt,
   output logic [WIDTH-1:0] step_val,
   output logic             step_carry,
   output logic             last
);

   logic [WIDTH-1:0] val_q;
   logic [SHW-1:0]   cnt_q;
   logic [3:0]       op_q;

   // step_val/step_carry describe the value after the next step, so the core can finish on the last one
   always_comb begin
      step_val   = {1'b0, val_q[WIDTH-1:1]};
      step_carry = val_q[0];
      if (op_q == OP_SHL) begin
         step_val   = {val_q[WIDTH-2:0], 1'b0};
         step_carry = val_q[WIDTH-1];
      end else if (op_q == OP_SHRA) begin
         step_val   = {val_q[WIDTH-1], val_q[WIDTH-1:1]};
      end
   end

   assign last = (cnt_q == SHW'(1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         val_q <= '0;
         cnt_q <= '0;
         op_q  <= '0;
      end else if (load) begin
         val_q <= data;
         cnt_q <= shamt;
         op_q  <= op;
      end else if (step) begin
         val_q <= step_val;
         cnt_q <= cnt_q - SHW'(1);
      end
   end

endmodule
`endif

// File: rtl/alu_seq_core.sv
// rtl/alu_seq_core.sv - registered ALU with valid/ready ports and Z/N/C/V flags
// ALU_SHIFT_EN enables iterative SHL/SHR/SHRA; otherwise those opcodes yield 0.
module alu_seq_core
   import alu_seq_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int INC_CONST = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_ci,
   input  logic [3:0]       in_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_res,
   output logic             out_z,
   output logic             out_n,
   output logic             out_c,
   output logic             out_v
);

   localparam int SHW = $clog2(WIDTH);
   localparam logic [WIDTH:0] KCONST = (WIDTH+1)'(INC_CONST);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [3:0]       flags_q, flags_d;
   logic [WIDTH:0]   a1, b1, ci1, alu_wide;
   logic [WIDTH-1:0] alu_r;
   logic             alu_c, alu_v, accept;

   function automatic logic [3:0] mk_flags(input logic [WIDTH-1:0] r, input logic c, input logic v);
      logic [3:0] f;
      f         = '0;
      f[FLAG_Z] = (r == '0);
      f[FLAG_N] = r[WIDTH-1];
      f[FLAG_C] = c;
      f[FLAG_V] = v;
      return f;
   endfunction

   assign out_valid = (state_q == ST_DONE);
   assign in_ready  = (state_q != ST_SHIFT) && (!out_valid || out_ready);
   assign accept    = in_valid && in_ready;
   assign out_res   = res_q;
   assign out_z     = flags_q[FLAG_Z];
   assign out_n     = flags_q[FLAG_N];
   assign out_c     = flags_q[FLAG_C];
   assign out_v     = flags_q[FLAG_V];

   assign a1  = {1'b0, in_a};
   assign b1  = {1'b0, in_b};
   assign ci1 = {{WIDTH{1'b0}}, in_ci};

   // Arithmetic is done one bit wider so the carry/borrow falls out of bit WIDTH
   always_comb begin
      alu_wide = '0;
      alu_c    = 1'b0;
      alu_v    = 1'b0;
      case (in_op)
         OP_ADD, OP_ADDC: begin
            alu_wide = a1 + b1 + ((in_op == OP_ADDC) ? ci1 : '0);
            alu_c    = alu_wide[WIDTH];
            alu_v    = ~(in_a[WIDTH-1] ^ in_b[WIDTH-1]) & (in_a[WIDTH-1] ^ alu_wide[WIDTH-1]);
         end
         OP_SUB: begin
            alu_wide = a1 - b1;
            alu_c    = (in_a < in_b);
            alu_v    = (in_a[WIDTH-1] ^ in_b[WIDTH-1]) & (in_a[WIDTH-1] ^ alu_wide[WIDTH-1]);
         end
         OP_SUBB: begin
            alu_wide = a1 - b1 - ci1;
            alu_c    = (a1 < (b1 + ci1));
            alu_v    = (in_a[WIDTH-1] ^ in_b[WIDTH-1]) & (in_a[WIDTH-1] ^ alu_wide[WIDTH-1]);
         end
         OP_RSUB: begin
            alu_wide = b1 - a1;
            alu_c    = (in_a > in_b);
         end
         OP_OR:    alu_wide = {1'b0, in_a | in_b};
         OP_XOR:   alu_wide = {1'b0, in_a ^ in_b};
         OP_AND:   alu_wide = {1'b0, in_a & in_b};
         OP_PASSA: alu_wide = a1;
         OP_ADDK:  alu_wide = a1 + KCONST;
         OP_PASSB: alu_wide = b1;
`ifdef ALU_SHIFT_EN
         OP_SHL, OP_SHR, OP_SHRA: alu_wide = a1;
`endif
         default:  alu_wide = '0;
      endcase
   end

   assign alu_r = alu_wide[WIDTH-1:0];

`ifdef ALU_SHIFT_EN
   logic             sh_load, sh_step, sh_carry, sh_last, is_shift;
   logic [WIDTH-1:0] sh_val;

   assign is_shift = (in_op == OP_SHL) || (in_op == OP_SHR) || (in_op == OP_SHRA);

   alu_shift_unit #(.WIDTH(WIDTH)) u_shift (
      .clk        (clk),
      .reset      (reset),
      .load       (sh_load),
      .step       (sh_step),
      .op         (in_op),
      .data       (in_a),
      .shamt      (in_b[SHW-1:0]),
      .step_val   (sh_val),
      .step_carry (sh_carry),
      .last       (sh_last)
   );
`endif

   always_comb begin
      state_d = state_q;
      res_d   = res_q;
      flags_d = flags_q;
`ifdef ALU_SHIFT_EN
      sh_load = 1'b0;
      sh_step = 1'b0;
`endif
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (accept) begin
               state_d = ST_DONE;
               res_d   = alu_r;
               flags_d = mk_flags(alu_r, alu_c, alu_v);
`ifdef ALU_SHIFT_EN
               if (is_shift && (in_b[SHW-1:0] != '0)) begin
                  state_d = ST_SHIFT;
                  res_d   = res_q;
                  flags_d = flags_q;
                  sh_load = 1'b1;
               end
`endif
            end else if (out_valid && out_ready) begin
               state_d = ST_IDLE;
            end
         end
         ST_SHIFT: begin
`ifdef ALU_SHIFT_EN
            sh_step = 1'b1;
            if (sh_last) begin
               state_d = ST_DONE;
               res_d   = sh_val;
               flags_d = mk_flags(sh_val, sh_carry, 1'b0);
            end
`else
            state_d = ST_IDLE;
`endif
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         res_q   <= '0;
         flags_q <= '0;
      end else begin
         state_q <= state_d;
         res_q   <= res_d;
         flags_q <= flags_d;
      end
   end

endmodule
